// File: rtl/fp_pkg.sv
// Shared floating-point definitions: default operand widths, normalizer
// FSM state encoding and the {sign, exp, frac} operand bundle used by fp_adder.
package fp_pkg;

    localparam int FP_EXP_W  = 4;
    localparam int FP_FRAC_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } norm_state_e;

    typedef struct packed {
        logic                 sign;
        logic [FP_EXP_W-1:0]  exp;
        logic [FP_FRAC_W-1:0] frac;
    } fp_op_t;

endpackage

// File: rtl/fp_lzc.sv
// Combinational leading-zero counter over the fraction.
// Ports: frac (FRAC_W) in; lz (clog2(FRAC_W+1)) out, equals FRAC_W for frac==0.
module fp_lzc
    import fp_pkg::*;
#(
    parameter int FRAC_W = FP_FRAC_W,
    parameter int LZ_W   = $clog2(FRAC_W + 1)
) (
    input  logic [FRAC_W-1:0] frac,
    output logic [LZ_W-1:0]   lz
);

    logic found;

    always_comb begin
        lz    = '0;
        found = 1'b0;
        for (int i = FRAC_W - 1; i >= 0; i--) begin
            if (!found) begin
                if (frac[i]) begin
                    found = 1'b1;
                end else begin
                    lz = lz + LZ_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/fp_normalizer.sv
// Pre-normalizer feeding fp_adder: shifts the fraction until its MSB is 1,
// decrementing the exponent per shift; flags exact zero and underflow flush.
// Ports: clk, reset_n (async active-low); in_valid/in_ready with sign_in,
// exp_in, frac_in; out_valid/out_ready with sign_out, exp_out, frac_out,
// zero, underflow.
// Build option: define FP_NORM_FAST_EN to resolve SHIFT in one cycle with a
// leading-zero counter instead of shifting one bit per cycle.
module fp_normalizer
    import fp_pkg::*;
#(
    parameter int EXP_W  = FP_EXP_W,
    parameter int FRAC_W = FP_FRAC_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              sign_in,
    input  logic [EXP_W-1:0]  exp_in,
    input  logic [FRAC_W-1:0] frac_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              sign_out,
    output logic [EXP_W-1:0]  exp_out,
    output logic [FRAC_W-1:0] frac_out,
    output logic              zero,
    output logic              underflow
);

    norm_state_e       state_q, state_d;
    logic              sign_q, sign_d;
    logic [EXP_W-1:0]  exp_q, exp_d;
    logic [FRAC_W-1:0] frac_q, frac_d;
    logic              zero_q, zero_d;
    logic              uf_q, uf_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;

`ifdef FP_NORM_FAST_EN
    localparam int LZ_W = $clog2(FRAC_W + 1);
    logic [LZ_W-1:0] lz;

    fp_lzc #(
        .FRAC_W (FRAC_W),
        .LZ_W   (LZ_W)
    ) u_lzc (
        .frac (frac_q),
        .lz   (lz)
    );
`endif

    always_comb begin
        state_d = state_q;
        sign_d  = sign_q;
        exp_d   = exp_q;
        frac_d  = frac_q;
        zero_d  = zero_q;
        uf_d    = uf_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = SHIFT;
                    sign_d  = sign_in;
                    exp_d   = exp_in;
                    frac_d  = frac_in;
                    zero_d  = 1'b0;
                    uf_d    = 1'b0;
                end
            end
            SHIFT: begin
`ifdef FP_NORM_FAST_EN
                state_d = DONE;
                if (frac_q == '0) begin
                    sign_d = 1'b0;
                    exp_d  = '0;
                    zero_d = 1'b1;
                end else if (int'(lz) > int'(exp_q)) begin
                    // Exponent would go negative: flush to zero.
                    frac_d = '0;
                    exp_d  = '0;
                    sign_d = 1'b0;
                    uf_d   = 1'b1;
                end else begin
                    frac_d = frac_q << lz;
                    exp_d  = exp_q - EXP_W'(lz);
                end
`else
                if (frac_q == '0) begin
                    sign_d  = 1'b0;
                    exp_d   = '0;
                    zero_d  = 1'b1;
                    state_d = DONE;
                end else if (frac_q[FRAC_W-1]) begin
                    state_d = DONE;
                end else if (exp_q == '0) begin
                    frac_d  = '0;
                    sign_d  = 1'b0;
                    uf_d    = 1'b1;
                    state_d = DONE;
                end else begin
                    frac_d = {frac_q[FRAC_W-2:0], 1'b0};
                    exp_d  = exp_q - EXP_W'(1);
                end
`endif
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            sign_q      <= 1'b0;
            exp_q       <= '0;
            frac_q      <= '0;
            zero_q      <= 1'b0;
            uf_q        <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sign_q      <= sign_d;
            exp_q       <= exp_d;
            frac_q      <= frac_d;
            zero_q      <= zero_d;
            uf_q        <= uf_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign sign_out  = sign_q;
    assign exp_out   = exp_q;
    assign frac_out  = frac_q;
    assign zero      = zero_q;
    assign underflow = uf_q;

endmodule
